// File: rtl/ws2812_pattern_gen.sv
// Purpose: per-frame animation source (solid/chase/rainbow/off) that streams LED writes to a ws2812 driver.
// Latency: first write 3 cycles after a frame tick, then one write every 2 cycles; frame_done rides the last write.
// Backpressure: none. A frame tick that arrives while a frame is still being written is dropped.
module ws2812_pattern_gen #(
    parameter int NUM_LEDS = 8,
    parameter int CLK_HZ   = 16000000,
    parameter int FRAME_HZ = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mode,
    input  logic [23:0] color,
    input  logic [7:0]  brightness,
    output logic [7:0]  led_num,
    output logic [23:0] rgb_data,
    output logic        write,
    output logic        busy,
    output logic        frame_done
);

    localparam int FRAME_DIV = CLK_HZ / FRAME_HZ;
    localparam int CW        = $clog2(FRAME_DIV);
    localparam int HUE_STEP  = 256 / NUM_LEDS;
    localparam logic [7:0] LAST_IDX = 8'(NUM_LEDS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, CALC, WRITE} state_t;

    state_t        state_q;
    logic [CW-1:0] frame_cnt_q;
    logic          tick;
    logic [7:0]    idx_q;
    logic [1:0]    mode_q;
    logic [23:0]   color_q;
    logic [7:0]    bright_q;
    logic [7:0]    phase_q;
    logic [7:0]    chase_q;
    logic [7:0]    led_q;
    logic [23:0]   rgb_q;
    logic          write_q;
    logic          busy_q;
    logic          done_q;
    logic [23:0]   rgb_d;

    // Channel scale: (ch * (b+1)) >> 8, so b=255 passes through and b=0 blanks.
    function automatic logic [7:0] scale(input logic [7:0] ch, input logic [7:0] b);
        logic [15:0] prod;
        prod = 16'(ch) * (16'(b) + 16'd1);
        return prod[15:8];
    endfunction

    assign tick = (frame_cnt_q == CW'(FRAME_DIV - 1));

    // Free-running frame divider; wraps every FRAME_DIV cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else if (tick) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_q + CW'(1);
        end
    end

    // Colour of the current index from the frame-latched controls, then brightness-scaled.
    always_comb begin
        logic [15:0] hue_off;
        logic [7:0]  hue;
        logic [7:0]  seg;
        logic [7:0]  tri3;
        logic [23:0] raw;
        hue_off = 16'(idx_q) * 16'(HUE_STEP);
        hue     = phase_q + hue_off[7:0];
        seg     = 8'd0;
        tri3    = 8'd0;
        raw     = 24'h000000;
        case (mode_q)
            2'd0: raw = color_q;
            2'd1: raw = (idx_q == chase_q) ? color_q : 24'h000000;
            2'd2: begin
                if (hue < 8'd85) begin
                    seg  = hue;
                    tri3 = (seg << 1) + seg;
                    raw  = {8'd255 - tri3, tri3, 8'd0};
                end else if (hue < 8'd170) begin
                    seg  = hue - 8'd85;
                    tri3 = (seg << 1) + seg;
                    raw  = {8'd0, 8'd255 - tri3, tri3};
                end else begin
                    seg  = hue - 8'd170;
                    tri3 = (seg << 1) + seg;
                    raw  = {tri3, 8'd0, 8'd255 - tri3};
                end
            end
            default: raw = 24'h000000;
        endcase
        rgb_d = {scale(raw[23:16], bright_q), scale(raw[15:8], bright_q), scale(raw[7:0], bright_q)};
    end

    // Frame sequencer: IDLE -> LOAD -> (CALC -> WRITE) x NUM_LEDS -> IDLE, all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= 8'd0;
            mode_q   <= 2'd0;
            color_q  <= 24'h000000;
            bright_q <= 8'd0;
            phase_q  <= 8'd0;
            chase_q  <= 8'd0;
            led_q    <= 8'd0;
            rgb_q    <= 24'h000000;
            write_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            write_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tick) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    mode_q   <= mode;
                    color_q  <= color;
                    bright_q <= brightness;
                    idx_q    <= 8'd0;
                    state_q  <= CALC;
                end
                CALC: begin
                    write_q <= 1'b1;
                    led_q   <= idx_q;
                    rgb_q   <= rgb_d;
                    done_q  <= (idx_q == LAST_IDX);
                    state_q <= WRITE;
                end
                WRITE: begin
                    if (idx_q == LAST_IDX) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        phase_q <= phase_q + 8'd1;
                        chase_q <= (chase_q == LAST_IDX) ? 8'd0 : chase_q + 8'd1;
                    end else begin
                        idx_q   <= idx_q + 8'd1;
                        state_q <= CALC;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign led_num    = led_q;
    assign rgb_data   = rgb_q;
    assign write      = write_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_ws2812_pattern_gen.sv
// Bench for ws2812_pattern_gen with FRAME_DIV=100, NUM_LEDS=8.
// Driver queues the expected writes (LED, colour, frame_done, cycle) as it sets controls;
// a negedge monitor pops one entry per observed write and compares all fields.
module tb_ws2812_pattern_gen;

    logic        clk;
    logic        reset;
    logic [1:0]  mode;
    logic [23:0] color;
    logic [7:0]  brightness;
    logic [7:0]  led_num;
    logic [23:0] rgb_data;
    logic        write;
    logic        busy;
    logic        frame_done;

    typedef struct packed {
        logic [7:0]  led;
        logic [23:0] rgb;
        logic        fd;
        logic [31:0] cyc;
    } exp_t;

    exp_t        sbq[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] cyc = 0;
    logic        prev_fd = 1'b0;
    logic [23:0] rb0 [8];
    logic [23:0] rb1 [8];

    ws2812_pattern_gen #(.NUM_LEDS(8), .CLK_HZ(1000), .FRAME_HZ(10)) dut (
        .clk(clk), .reset(reset), .mode(mode), .color(color), .brightness(brightness),
        .led_num(led_num), .rgb_data(rgb_data), .write(write), .busy(busy), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index since reset release; equals the DUT frame divider count modulo 100.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic push_item(input logic [31:0] c, input logic [7:0] l, input logic [23:0] v, input logic fd);
        exp_t e;
        e.led = l; e.rgb = v; e.fd = fd; e.cyc = c;
        sbq.push_back(e);
    endtask

    task automatic push_solid(input logic [31:0] base, input logic [23:0] v);
        for (int i = 0; i < 8; i++) push_item(base + 32'(2 * i), 8'(i), v, i == 7);
    endtask

    task automatic push_chase(input logic [31:0] base, input int pos, input logic [23:0] v);
        for (int i = 0; i < 8; i++) push_item(base + 32'(2 * i), 8'(i), (i == pos) ? v : 24'h000000, i == 7);
    endtask

    task automatic push_tab(input logic [31:0] base, input int which);
        for (int i = 0; i < 8; i++) push_item(base + 32'(2 * i), 8'(i), (which == 0) ? rb0[i] : rb1[i], i == 7);
    endtask

    task automatic wait_cyc(input logic [31:0] c);
        int guard;
        guard = 0;
        while (cyc != c && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != c) begin
            errors++; checks++;
            $display("FAIL wait_cyc: cycle counter is %0d, required %0d", cyc, c);
        end
    endtask

    task automatic check_empty(input string name);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected writes never seen, required 0", name, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    // Scoreboard monitor: every write must match the head of the queue, including its cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (prev_fd) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_after_done: busy=%b, required 0", busy);
                end
            end
            prev_fd = (frame_done === 1'b1);
            if (frame_done === 1'b1) begin
                checks++;
                if (write !== 1'b1) begin
                    errors++;
                    $display("FAIL done_without_write: write=%b, required 1", write);
                end
            end
            if (write === 1'b1) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: cyc=%0d led=%0d rgb=%h, required no write", cyc, led_num, rgb_data);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    if (led_num !== e.led || rgb_data !== e.rgb || frame_done !== e.fd || cyc !== e.cyc || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL write: got cyc=%0d led=%0d rgb=%h fd=%b busy=%b, required cyc=%0d led=%0d rgb=%h fd=%b busy=1",
                                 cyc, led_num, rgb_data, frame_done, busy, e.cyc, e.led, e.rgb, e.fd);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rb0 = '{24'hFF0000, 24'h9F6000, 24'h3FC000, 24'h00DE21, 24'h007E81, 24'h001EE1, 24'h4200BD, 24'hA2005D};
        rb1 = '{24'hFC0300, 24'h9C6300, 24'h3CC300, 24'h00DB24, 24'h007B84, 24'h001BE4, 24'h4500BA, 24'hA5005A};
        reset = 1'b1; mode = 2'd0; color = 24'h000000; brightness = 8'd255;

        // Solid, brightness scaling, zero brightness, mid-frame switch to off.
        do_reset();
        checks++;
        if (write !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: write=%b busy=%b frame_done=%b, required 0 0 0", write, busy, frame_done);
        end
        checks++;
        if (led_num !== 8'd0 || rgb_data !== 24'h000000) begin
            errors++;
            $display("FAIL reset_data: led_num=%h rgb_data=%h, required 00 000000", led_num, rgb_data);
        end
        mode = 2'd0; color = 24'h7F0000; brightness = 8'd255;
        push_solid(102, 24'h7F0000);
        wait_cyc(150);
        color = 24'hFF8040; brightness = 8'd127;
        push_solid(202, 24'h7F4020);
        wait_cyc(250);
        brightness = 8'd0;
        push_solid(302, 24'h000000);
        wait_cyc(350);
        color = 24'h123456; brightness = 8'd255;
        push_solid(402, 24'h123456);
        wait_cyc(406);
        mode = 2'd3;
        push_solid(502, 24'h000000);
        wait_cyc(560);
        check_empty("solid_frames");

        // Chase across all positions and its wrap back to LED 0.
        do_reset();
        mode = 2'd1; color = 24'h00FF00; brightness = 8'd255;
        for (int f = 0; f < 9; f++) push_chase(32'(102 + 100 * f), f % 8, 24'h00FF00);
        wait_cyc(960);
        check_empty("chase_frames");

        // Rainbow for phase 0 and phase 1.
        do_reset();
        mode = 2'd2; brightness = 8'd255;
        push_tab(102, 0);
        push_tab(202, 1);
        wait_cyc(260);
        check_empty("rainbow_frames");

        // Reset one cycle after the third write of a frame.
        do_reset();
        mode = 2'd1; color = 24'h0000FF; brightness = 8'd255;
        push_chase(102, 0, 24'h0000FF);
        push_item(202, 8'd0, 24'h000000, 1'b0);
        push_item(204, 8'd1, 24'h0000FF, 1'b0);
        push_item(206, 8'd2, 24'h000000, 1'b0);
        wait_cyc(207);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (write !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset: write=%b busy=%b frame_done=%b, required 0 0 0", write, busy, frame_done);
        end
        check_empty("partial_frame");
        reset = 1'b0;
        push_chase(102, 0, 24'h0000FF);
        wait_cyc(150);
        mode = 2'd2;
        push_tab(202, 1);
        wait_cyc(260);
        check_empty("after_reset_frames");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
